// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the core (c), loader (d) and data-memory (m) signals around dmem_port_arbiter.
// slave = arbiter side, master = requester/memory side.
interface dmem_port_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  c_req;
  logic                  c_we;
  logic [DM_ADDRESS-1:0] c_addr;
  logic [DATA_W-1:0]     c_wdata;
  logic [2:0]            c_funct3;
  logic                  c_gnt;
  logic                  c_rvalid;
  logic [DATA_W-1:0]     c_rdata;
  logic                  c_err;

  logic                  d_req;
  logic                  d_we;
  logic [DM_ADDRESS-1:0] d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [2:0]            d_funct3;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_err;

  logic [DM_ADDRESS-1:0] m_addr;
  logic                  m_re;
  logic                  m_we;
  logic [3:0]            m_be;
  logic [DATA_W-1:0]     m_wdata;
  logic [DATA_W-1:0]     m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_funct3,
    output c_gnt, c_rvalid, c_rdata, c_err,
    input  d_req, d_we, d_addr, d_wdata, d_funct3,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output m_addr, m_re, m_we, m_be, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_funct3,
    input  c_gnt, c_rvalid, c_rdata, c_err,
    output d_req, d_we, d_addr, d_wdata, d_funct3,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  m_addr, m_re, m_we, m_be, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin scheduler of core and loader accesses onto a 1-cycle-latency word memory,
// with one outstanding transaction, byte-lane write steering and load extension.
//
// state | meaning
// IDLE  | arbitrate; grant pulse and field latch happen here
// RD    | memory read strobe
// WR    | memory write strobe with byte enables
// RESP  | completion pulse to the owner port
module dmem_port_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input logic               clk,
  input logic               reset_n,
  dmem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t                state_q, state_d;
  logic                  last_d_q;
  logic                  owner_q;
  logic                  we_q;
  logic                  err_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [2:0]            f3_q;

  logic                  req_any;
  logic                  pick_d;
  logic                  grant;
  logic                  sel_we;
  logic [DM_ADDRESS-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic [2:0]            sel_f3;
  logic                  sel_err;

  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = a[0];
      3'b010:  bad = |a;
      3'b100:  bad = we;
      3'b101:  bad = we | a[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // last_d_q = 1 means the loader was granted last, so the core wins a tie
  assign req_any   = bus.c_req | bus.d_req;
  assign pick_d    = bus.d_req & (~bus.c_req | ~last_d_q);
  assign sel_we    = pick_d ? bus.d_we     : bus.c_we;
  assign sel_addr  = pick_d ? bus.d_addr   : bus.c_addr;
  assign sel_wdata = pick_d ? bus.d_wdata  : bus.c_wdata;
  assign sel_f3    = pick_d ? bus.d_funct3 : bus.c_funct3;
  assign sel_err   = access_err(sel_we, sel_f3, sel_addr[1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      f3_q     <= 3'b000;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q  <= pick_d;
        last_d_q <= pick_d;
        we_q     <= sel_we;
        err_q    <= sel_err;
        addr_q   <= sel_addr;
        wdata_q  <= sel_wdata;
        f3_q     <= sel_f3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          grant = 1'b1;
          if (sel_err)     state_d = RESP;
          else if (sel_we) state_d = WR;
          else             state_d = RD;
        end
      end
      RD:      state_d = RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant is combinational in IDLE; qualify it with reset so nothing leaks out while held in reset
  assign bus.c_gnt = grant & ~pick_d & reset_n;
  assign bus.d_gnt = grant &  pick_d & reset_n;

  logic              in_rd, in_wr, in_resp;
  logic [3:0]        be;
  logic [DATA_W-1:0] wlanes;

  assign in_rd   = (state_q == RD);
  assign in_wr   = (state_q == WR);
  assign in_resp = (state_q == RESP);

  always_comb begin
    be     = 4'b0000;
    wlanes = '0;
    if (in_wr) begin
      case (f3_q[1:0])
        2'b00: begin
          be     = 4'b0001 << addr_q[1:0];
          wlanes = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          be     = addr_q[1] ? 4'b1100 : 4'b0011;
          wlanes = {2{wdata_q[15:0]}};
        end
        default: begin
          be     = 4'b1111;
          wlanes = wdata_q;
        end
      endcase
    end
  end

  assign bus.m_re    = in_rd;
  assign bus.m_we    = in_wr;
  assign bus.m_be    = be;
  assign bus.m_wdata = wlanes;
  assign bus.m_addr  = (in_rd | in_wr) ? {addr_q[DM_ADDRESS-1:2], 2'b00} : '0;

  logic [DATA_W-1:0] rshift;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] resp_data;

  always_comb begin
    rshift   = bus.m_rdata >> {addr_q[1:0], 3'b000};
    lane_b   = rshift[7:0];
    lane_h   = addr_q[1] ? bus.m_rdata[31:16] : bus.m_rdata[15:0];
    load_val = '0;
    case (f3_q)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b010:  load_val = bus.m_rdata;
      3'b100:  load_val = {24'b0, lane_b};
      3'b101:  load_val = {16'b0, lane_h};
      default: load_val = '0;
    endcase
  end

  // m_rdata is only meaningful in RESP, the cycle after the RD strobe
  assign resp_data = (in_resp && !we_q && !err_q) ? load_val : '0;

  assign bus.c_rvalid = in_resp & ~owner_q;
  assign bus.d_rvalid = in_resp &  owner_q;
  assign bus.c_rdata  = bus.c_rvalid ? resp_data : '0;
  assign bus.d_rdata  = bus.d_rvalid ? resp_data : '0;
  assign bus.c_err    = bus.c_rvalid & err_q;
  assign bus.d_err    = bus.d_rvalid & err_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: a reference memory and access model predict
// every memory strobe and completion, which are checked as the DUT produces them.
module tb_dmem_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.DM_ADDRESS(AW), .DATA_W(DW)) bus ();

  dmem_port_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    bit          err;
    int          due;
  } resp_t;

  typedef struct {
    bit          we;
    logic [8:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          due;
  } acc_t;

  resp_t rq[$];
  acc_t  aq[$];
  bit    gport[$];
  int    gcyc[$];

  logic [31:0] mem [128];
  logic [31:0] ref_mem [128];
  bit          mem_init = 1'b0;
  bit          ref_init = 1'b0;
  int          cyc = 0;

  function automatic logic [31:0] seed_word(input int i);
    return 32'(i) * 32'h9E37_79B1 + 32'h0F1E_2D3C;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory seen by the DUT: synchronous read, byte-enabled write
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= seed_word(i);
      mem_init <= 1'b1;
    end else begin
      if (bus.m_re) bus.m_rdata <= mem[bus.m_addr[8:2]];
      if (bus.m_we)
        for (int i = 0; i < 4; i++)
          if (bus.m_be[i]) mem[bus.m_addr[8:2]][8*i +: 8] <= bus.m_wdata[8*i +: 8];
    end
  end

  task automatic model(input bit port);
    logic        we;
    logic [8:0]  a;
    logic [31:0] wd, w, rd, mwd;
    logic [2:0]  f3;
    logic [3:0]  be;
    logic [7:0]  b;
    logic [15:0] h;
    bit          bad;
    resp_t       r;
    acc_t        x;
    we  = port ? bus.d_we     : bus.c_we;
    a   = port ? bus.d_addr   : bus.c_addr;
    wd  = port ? bus.d_wdata  : bus.c_wdata;
    f3  = port ? bus.d_funct3 : bus.c_funct3;
    case (f3)
      3'b000, 3'b001, 3'b010: bad = 1'b0;
      3'b100, 3'b101:         bad = we;
      default:                bad = 1'b1;
    endcase
    if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) bad = 1'b1;
    if (f3 == 3'b010 && a[1:0] != 2'b00) bad = 1'b1;
    gport.push_back(port);
    gcyc.push_back(cyc);
    rd = '0;
    if (!bad) begin
      w       = ref_mem[a[8:2]];
      x.we    = we;
      x.addr  = a;
      x.due   = cyc + 1;
      x.be    = 4'b0000;
      x.wdata = '0;
      if (we) begin
        case (f3)
          3'b000:  begin be = 4'b0001 << a[1:0]; mwd = {4{wd[7:0]}}; end
          3'b001:  begin be = a[1] ? 4'b1100 : 4'b0011; mwd = {2{wd[15:0]}}; end
          default: begin be = 4'b1111; mwd = wd; end
        endcase
        x.be    = be;
        x.wdata = mwd;
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = mwd[8*i +: 8];
        ref_mem[a[8:2]] = w;
      end else begin
        b = w[int'(a[1:0])*8 +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
          3'b000:  rd = {{24{b[7]}}, b};
          3'b001:  rd = {{16{h[15]}}, h};
          3'b010:  rd = w;
          3'b100:  rd = {24'b0, b};
          default: rd = {16'b0, h};
        endcase
      end
      aq.push_back(x);
    end
    r.port  = port;
    r.rdata = rd;
    r.err   = bad;
    r.due   = bad ? cyc + 1 : cyc + 2;
    rq.push_back(r);
  endtask

  always @(negedge clk) begin
    acc_t  x;
    resp_t r;
    if (!ref_init) begin
      for (int i = 0; i < 128; i++) ref_mem[i] = seed_word(i);
      ref_init = 1'b1;
    end
    if (reset_n) begin
      chk("re_we_excl", 32'(bus.m_re & bus.m_we), 0);
      if (!bus.m_re && !bus.m_we)
        chk("mem_quiet", 32'((|bus.m_addr) | (|bus.m_be) | (|bus.m_wdata)), 0);
      else if (!bus.m_we)
        chk("be_on_read", 32'(bus.m_be), 0);
      chk("dual_gnt", 32'(bus.c_gnt & bus.d_gnt), 0);
      chk("dual_rvalid", 32'(bus.c_rvalid & bus.d_rvalid), 0);
      if (!bus.c_rvalid) chk("c_quiet", 32'((|bus.c_rdata) | bus.c_err), 0);
      if (!bus.d_rvalid) chk("d_quiet", 32'((|bus.d_rdata) | bus.d_err), 0);
      if (bus.m_re || bus.m_we) begin
        if (aq.size() == 0) chk("strobe_unexpected", 1, 0);
        else begin
          x = aq.pop_front();
          chk("acc_kind", 32'(bus.m_we), 32'(x.we));
          chk("acc_cycle", cyc, x.due);
          chk("m_addr", 32'(bus.m_addr), 32'({x.addr[8:2], 2'b00}));
          if (x.we) begin
            chk("m_be", 32'(bus.m_be), 32'(x.be));
            chk("m_wdata", bus.m_wdata, x.wdata);
          end
        end
      end
      if (bus.c_rvalid || bus.d_rvalid) begin
        if (rq.size() == 0) chk("rvalid_unexpected", 1, 0);
        else begin
          r = rq.pop_front();
          chk("resp_port", 32'(bus.d_rvalid), 32'(r.port));
          chk("resp_cycle", cyc, r.due);
          chk("rdata", bus.d_rvalid ? bus.d_rdata : bus.c_rdata, r.rdata);
          chk("err", 32'(bus.d_rvalid ? bus.d_err : bus.c_err), 32'(r.err));
        end
      end
      if (bus.c_gnt) model(1'b0);
      if (bus.d_gnt) model(1'b1);
    end
  end

  task automatic issue(input bit port, input bit we, input logic [8:0] a,
                       input logic [31:0] wd, input logic [2:0] f3, input bit keep);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    if (!port) begin
      bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = a; bus.c_wdata = wd; bus.c_funct3 = f3;
    end else begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; bus.d_funct3 = f3;
    end
    while (!got && n < 40) begin
      @(negedge clk);
      got = port ? bus.d_gnt : bus.c_gnt;
      n++;
    end
    if (!got) chk(port ? "d_gnt_timeout" : "c_gnt_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep || !got) begin
      if (!port) bus.c_req = 1'b0;
      else       bus.d_req = 1'b0;
    end
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_ctl"}, 32'({bus.c_gnt, bus.c_rvalid, bus.c_err, bus.d_gnt, bus.d_rvalid,
                            bus.d_err, bus.m_re, bus.m_we, bus.m_be}), 0);
    chk({tag, "_c_rdata"}, bus.c_rdata, 0);
    chk({tag, "_d_rdata"}, bus.d_rdata, 0);
    chk({tag, "_m_addr"}, 32'(bus.m_addr), 0);
    chk({tag, "_m_wdata"}, bus.m_wdata, 0);
  endtask

  task automatic drain(input string tag);
    repeat (4) @(negedge clk);
    chk({tag, "_resp_left"}, rq.size(), 0);
    chk({tag, "_acc_left"}, aq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    idx0;
    bit    p;
    bit    w;
    logic [2:0] f;
    logic [8:0] a;
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0; bus.c_funct3 = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_funct3 = '0;
    #1 reset_n = 1'b0;
    #2 outputs_zero("reset");
    bus.c_req = 1'b1;
    bus.d_req = 1'b1;
    #1 chk("reset_gnt_gated", 32'({bus.c_gnt, bus.d_gnt}), 0);
    bus.c_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Core SW 0x010
    issue(0, 1, 9'h010, 32'hDEAD_BEEF, 3'b010, 0);
    @(negedge clk);
    chk("sw_m_we", 32'(bus.m_we), 1);
    chk("sw_m_be", 32'(bus.m_be), 32'hF);
    chk("sw_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("sw_rvalid", 32'({bus.c_rvalid, bus.c_err}), 32'b10);
    @(posedge clk);
    #1;

    // Loader SB 0x013, then core LB / LBU of the same byte
    issue(1, 1, 9'h013, 32'h0000_00A5, 3'b000, 0);
    @(negedge clk);
    chk("sb_m_be", 32'(bus.m_be), 32'b1000);
    chk("sb_m_wdata", bus.m_wdata, 32'hA5A5_A5A5);
    @(posedge clk);
    #1;
    issue(0, 0, 9'h013, '0, 3'b000, 0);
    @(negedge clk);
    @(negedge clk);
    chk("lb_rdata", bus.c_rdata, 32'hFFFF_FFA5);
    @(posedge clk);
    #1;
    issue(0, 0, 9'h013, '0, 3'b100, 0);
    @(negedge clk);
    @(negedge clk);
    chk("lbu_rdata", bus.c_rdata, 32'h0000_00A5);
    @(posedge clk);
    #1;
    drain("basic");

    // Both ports requesting continuously
    idx0 = gport.size();
    fork
      begin
        for (int i = 0; i < 4; i++)
          issue(0, 0, 9'(9'h040 + 9'(8 * i)), '0, 3'b010, i < 3);
      end
      begin
        for (int i = 0; i < 4; i++)
          issue(1, 0, 9'(9'h062 + 9'(4 * i)), '0, 3'b101, i < 3);
      end
    join
    drain("rr");
    chk("rr_grants", gport.size() - idx0, 8);
    for (int k = idx0 + 1; k < gport.size(); k++) begin
      chk("rr_alternate", 32'(gport[k]), 32'(!gport[k-1]));
      chk("gnt_spacing", gcyc[k] - gcyc[k-1], 3);
    end

    // Misaligned and unsupported accesses
    issue(0, 0, 9'h006, '0, 3'b010, 0);
    @(negedge clk);
    chk("lw_mis_err", 32'({bus.c_rvalid, bus.c_err}), 32'b11);
    @(posedge clk);
    #1;
    issue(0, 0, 9'h005, '0, 3'b001, 0);
    issue(0, 0, 9'h008, '0, 3'b011, 0);
    issue(1, 1, 9'h008, 32'h1234_5678, 3'b100, 0);
    issue(1, 1, 9'h00A, 32'h1234_5678, 3'b010, 0);
    drain("err");

    // Mixed legal traffic, alternating ports
    for (int i = 0; i < 16; i++) begin
      p = 1'(i % 2);
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       f = 3'b000;
        1:       f = 3'b001;
        default: f = 3'b010;
      endcase
      if (!w && f != 3'b010 && $urandom_range(0, 1) == 1) f[2] = 1'b1;
      a = 9'($urandom_range(0, 511));
      if (f[1:0] == 2'b01) a[0] = 1'b0;
      if (f[1:0] == 2'b10) a[1:0] = 2'b00;
      issue(p, w, a, $urandom, f, 0);
    end
    drain("mixed");

    // Reset in the strobe cycle of a core load
    issue(0, 0, 9'h020, '0, 3'b010, 0);
    #1 reset_n = 1'b0;
    rq.delete();
    aq.delete();
    #1 outputs_zero("mid_reset");
    @(negedge clk);
    #2 reset_n = 1'b1;
    idx0 = gport.size();
    @(posedge clk);
    #1;
    fork
      issue(0, 0, 9'h024, '0, 3'b010, 0);
      issue(1, 0, 9'h028, '0, 3'b010, 0);
    join
    drain("post_reset");
    chk("post_reset_grants", gport.size() - idx0, 2);
    if (gport.size() - idx0 >= 2) begin
      chk("post_reset_first", 32'(gport[idx0]), 0);
      chk("post_reset_second", 32'(gport[idx0+1]), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Two-requester scheduler in front of the word-organised data memory (9-bit byte address, 32-bit data, per-byte write enables, 1-cycle read latency).
- Arbitrates round-robin between the core load/store path (port c) and the program-loader/DMA path (port d).
- Sequences each access as a one-outstanding transaction: memory read or write, then response.
- Generates byte enables and lane-replicated write data, and performs load extraction and extension per funct3.

Parameters:
DM_ADDRESS, 9, byte-address width of the data memory
DATA_W, 32, data word width (only 32 is supported)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
c_req  in  1  core request; hold stable with its fields until c_gnt
c_we  in  1  1=store, 0=load
c_addr  in  DM_ADDRESS  byte address
c_wdata  in  DATA_W  store data, right-aligned
c_funct3  in  3  RV32 load/store funct3
c_gnt  out  1  1-cycle pulse: request accepted, fields latched
c_rvalid  out  1  1-cycle completion pulse
c_rdata  out  DATA_W  load result, valid with c_rvalid; 0 for stores and errors
c_err  out  1  valid with c_rvalid: misaligned or unsupported funct3
d_req, d_we, d_addr, d_wdata, d_funct3, d_gnt, d_rvalid, d_rdata, d_err  same as c_*, for the loader port
m_addr  out  DM_ADDRESS  word-aligned address {addr[8:2],2'b00}
m_re  out  1  memory read strobe
m_we  out  1  memory write strobe
m_be  out  4  byte write enables
m_wdata  out  DATA_W  lane-replicated write data
m_rdata  in  DATA_W  memory read data, valid the cycle after m_re

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0; rr pointer = d, so the core wins the first tie.
- FSM states: IDLE, RD, WR, RESP.
- IDLE arbitration:
  - Only one req high: grant it.
  - Both high: grant the port not granted last; rr pointer updates on every grant.
  - Grant cycle: gnt pulse; latch id, we, addr, wdata, funct3; run the error check.
- Error check and next state:
  - Error → RESP with err=1 and no memory access.
  - Valid load → RD. Valid store → WR.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is an error.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0; a violation is an error.
- RD (1 cycle): m_re=1, m_addr driven → RESP.
- RESP for a load:
  - Capture m_rdata; select lane by addr[1:0] (byte) or addr[1] (half).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- WR (1 cycle): m_we=1 → RESP.
  - SB: m_be = 4'b0001 << addr[1:0]; m_wdata = {4{wdata[7:0]}}.
  - SH: m_be = addr[1] ? 4'b1100 : 4'b0011; m_wdata = {2{wdata[15:0]}}.
  - SW: m_be = 4'b1111; m_wdata = wdata.
- RESP (1 cycle): rvalid=1 on the owner port only, with its rdata and err → IDLE.
- Latency: gnt at T, memory strobe at T+1, rvalid at T+2 (error: rvalid at T+1); sustained one transaction per 3 cycles.
- Strobe rules:
  - m_re and m_we are never high together.
  - m_be = 0 when m_we = 0.
  - m_addr, m_wdata, m_be are 0 outside RD/WR.
- req seen outside IDLE is ignored; a req still high on return to IDLE is a new request.
- Losing requester keeps req high and is granted at the next IDLE; no starvation.
- Reset mid-transaction: aborts immediately, with no rvalid and no further memory strobe.

Test Plan:
- Core SW addr 0x010, wdata 0xDEADBEEF → c_gnt T; T+1 m_we=1, m_addr 0x010, m_be 1111, m_wdata 0xDEADBEEF; T+2 c_rvalid=1, c_err=0.
- Loader SB addr 0x013 wdata 0x000000A5, then core LB and LBU at 0x013 (m_rdata 0xA5xxxxxx) → store: m_be 1000, m_wdata 0xA5A5A5A5; LB rdata 0xFFFFFFA5; LBU rdata 0x000000A5; each rvalid 2 cycles after gnt.
- Both req held continuously, loads → grants alternate c,d,c,d; gnt spacing 3 cycles; no rvalid on the wrong port.
- Core LW addr 0x006 and LH addr 0x005 → rvalid at T+1 with err=1, rdata 0; m_re/m_we stay 0.
- funct3 011 load, then 100 store → err=1, no memory strobe.
- reset_n low in cycle after a core load gnt → all outputs 0 asynchronously; after release, simultaneous requests grant core first.
